// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the DM stage
// and the debug/loader port.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    S_CPU_PRI   = 1'b0,
    S_DBG_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CPU  = 2'd1,
    G_DBG  = 2'd2
  } grant_t;

  localparam logic [3:0] XFER_DWORD   = 4'b1000;
  localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Counts consecutive cycles the debug port lost arbitration; hit fires on the
// loss that reaches the limit, and the count restarts from zero after it.
module arb_starve_counter
  import dmem_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  input  logic [STARVE_CNT_W-1:0] limit,
  output logic                    hit,
  output logic [STARVE_CNT_W-1:0] count
);

  logic [STARVE_CNT_W-1:0] cnt;

  assign hit   = inc && (cnt == (limit - 1'b1));
  assign count = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || hit) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: cpu port has priority, debug port gets a forced grant
// after STARVE_LIMIT lost cycles. Optional counters under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  input  logic                    dbg_req,
  input  logic                    dbg_wr,
  input  logic [ADDR_W-1:0]       dbg_addr,
  input  logic [DATA_W-1:0]       dbg_wdata,
  output logic                    dbg_ack,
  output logic [DATA_W-1:0]       dbg_rdata,
  output logic                    dbg_rvalid,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [3:0]              mem_xfer,
  input  logic [DATA_W-1:0]       mem_rdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic                    stat_clr,
  output logic [31:0]             stat_conflict,
  output logic [31:0]             stat_cpu_stall,
`endif
  output logic [0:0]              arbState,
  output logic [STARVE_CNT_W-1:0] starveCnt
);

  // Handshake: cpu_req is a single-cycle request that completes when
  // cpu_stall is low; dbg_req is held until dbg_ack, and a read returns
  // data with dbg_rvalid exactly one cycle after its ack.

  arb_state_t state;
  arb_state_t stateNext;
  grant_t     grant;
  logic       forceActive;
  logic       cpuGrant;
  logic       dbgGrant;
  logic       starveInc;
  logic       starveClr;
  logic       starveHit;

  // A forced slot with no debug request behaves like a normal cpu-priority cycle.
  assign forceActive = (state == S_DBG_FORCE) && dbg_req;

  always_comb begin
    grant = G_NONE;
    if (forceActive) begin
      grant = G_DBG;
    end else if (cpu_req) begin
      grant = G_CPU;
    end else if (dbg_req) begin
      grant = G_DBG;
    end
  end

  assign cpuGrant  = (grant == G_CPU);
  assign dbgGrant  = (grant == G_DBG);
  assign starveInc = cpu_req && dbg_req && !forceActive;
  assign starveClr = dbgGrant || !dbg_req;
  assign stateNext = starveHit ? S_DBG_FORCE : S_CPU_PRI;

  arb_starve_counter u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starveInc),
    .clr   (starveClr),
    .limit (STARVE_CNT_W'(STARVE_LIMIT)),
    .hit   (starveHit),
    .count (starveCnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_CPU_PRI;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (grant)
      G_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_wr;
        mem_re    = !cpu_wr;
      end
      G_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_wr;
        mem_re    = !dbg_wr;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  assign mem_xfer  = XFER_DWORD;
  assign cpu_rdata = mem_rdata;
  assign cpu_stall = cpu_req && !cpuGrant;
  assign dbg_ack   = dbgGrant;
  assign arbState  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbgGrant && !dbg_wr;
      if (dbgGrant && !dbg_wr) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_conflict  <= '0;
      stat_cpu_stall <= '0;
    end else if (stat_clr) begin
      stat_conflict  <= '0;
      stat_cpu_stall <= '0;
    end else begin
      if (cpu_req && dbg_req && (stat_conflict != 32'hFFFF_FFFF)) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
      if (cpu_stall && (stat_cpu_stall != 32'hFFFF_FFFF)) begin
        stat_cpu_stall <= stat_cpu_stall + 32'd1;
      end
    end
  end
`endif

endmodule
